// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmit front end.
package uart_tx_fifo_pkg;

  localparam int DEPTH_LOG2_DEF = 4;
  localparam int DATA_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side write port plus the uart_8n1 handshake, bundled for the FIFO sequencer.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_W     = DATA_W_DEF
) ();

  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  sending;

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, level, overflow, tx_data, tx_start, sending
  );

  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, level, overflow, tx_data, tx_start, sending
  );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Simple dual-port byte array: synchronous write, asynchronous read so the
// sequencer can load the head byte in the same edge it pops it.
module uart_tx_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and send sequencer feeding uart_8n1: buffers producer bursts and
// issues one tx_start per byte, waiting for tx_busy to rise and fall between frames.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic           hclk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  overflow_reg;
  logic [DATA_W-1:0]     tx_data_reg;
  logic                  tx_start_reg;
  logic                  sending_reg;
  tx_state_t             state_reg;

  logic [DATA_W-1:0]     rd_data;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_accept;
  logic                  pop;

  assign full_w    = (level_reg == LEVEL_FULL);
  assign empty_w   = (level_reg == '0);
  assign wr_accept = bus.wr_en && !full_w;
  // A byte written this cycle is not visible to the pop check until next cycle.
  assign pop       = (state_reg == ST_IDLE) && !empty_w && !bus.tx_busy;

  always_comb begin
    level_next = level_reg;
    case ({wr_accept, pop})
      2'b10:   level_next = level_reg + LEVEL_ONE;
      2'b01:   level_next = level_reg - LEVEL_ONE;
      default: level_next = level_reg;
    endcase
  end

  uart_tx_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (hclk),
    .we    (wr_accept),
    .waddr (wr_ptr_reg),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      sending_reg  <= 1'b0;
      state_reg    <= ST_IDLE;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      level_reg <= level_next;
      // Drop decision uses the pre-edge level, so a same-cycle pop cannot rescue it.
      if (bus.wr_en && full_w) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            tx_data_reg  <= rd_data;
            tx_start_reg <= 1'b1;
            sending_reg  <= 1'b1;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          if (bus.tx_busy) begin
            tx_start_reg <= 1'b0;
            state_reg    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!bus.tx_busy) begin
            sending_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: begin
          tx_start_reg <= 1'b0;
          sending_reg  <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.level    = level_reg;
  assign bus.overflow = overflow_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_start = tx_start_reg;
  assign bus.sending  = sending_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a uart_8n1 stub (busy 1 cycle after
// tx_start, high for 10 cycles) that logs every frame it accepts.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  logic hclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 hclk = ~hclk;

  uart_tx_fifo_if #(.DEPTH_LOG2(4), .DATA_W(8)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .hclk  (hclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       stub_busy = 1'b0;
  logic       hold_busy = 1'b0;
  int         stub_cnt  = 0;
  logic [7:0] frame_log[$];

  int checks   = 0;
  int failures = 0;

  assign bus.tx_busy = stub_busy | hold_busy;

  // uart_8n1 stand-in; not reset, so a frame started before a reset completes.
  always @(posedge hclk) begin
    if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_busy <= 1'b0;
    end else if (bus.tx_start === 1'b1) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 10;
      frame_log.push_back(bus.tx_data);
      $display("frame %0d data=0x%02h", frame_log.size(), bus.tx_data);
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.wr_en  = 1'b0;
    tick();
    tick();
    rst_n      = 1'b1;
  endtask

  task automatic wait_idle(input int n_frames, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (frame_log.size() >= n_frames && bus.sending === 1'b0 &&
          bus.tx_busy === 1'b0 && bus.empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    rst_n       = 1'b0;
    tick();
    tick();
    checks++; if (bus.level !== 5'd0)     begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1)     begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0)      begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.tx_start !== 1'b0)  begin failures++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.sending !== 1'b0)   begin failures++; $display("FAIL reset_sending got=%b exp=0", bus.sending); end
    checks++; if (bus.tx_data !== 8'h00)  begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", bus.tx_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base;
    int cnt;
    base = frame_log.size();
    write_byte(8'h61);                      // edge N
    checks++; if (bus.level !== 5'd1)     begin failures++; $display("FAIL single_level_after_write got=%0d exp=1", bus.level); end
    checks++; if (bus.tx_start !== 1'b0)  begin failures++; $display("FAIL single_no_start_yet got=%b exp=0", bus.tx_start); end
    tick();                                 // edge N+1: pop, START
    checks++; if (bus.tx_start !== 1'b1)  begin failures++; $display("FAIL single_tx_start got=%b exp=1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h61)  begin failures++; $display("FAIL single_tx_data got=%02h exp=61", bus.tx_data); end
    checks++; if (bus.empty !== 1'b1)     begin failures++; $display("FAIL single_empty_after_pop got=%b exp=1", bus.empty); end
    checks++; if (bus.sending !== 1'b1)   begin failures++; $display("FAIL single_sending got=%b exp=1", bus.sending); end
    tick();                                 // edge N+2: busy rises, DUT has not seen it
    checks++; if (bus.tx_start !== 1'b1)  begin failures++; $display("FAIL single_start_held got=%b exp=1", bus.tx_start); end
    tick();                                 // edge N+3: DUT sees busy, DRAIN
    checks++; if (bus.tx_start !== 1'b0)  begin failures++; $display("FAIL single_start_dropped got=%b exp=0", bus.tx_start); end
    checks++; if (bus.sending !== 1'b1)   begin failures++; $display("FAIL single_sending_drain got=%b exp=1", bus.sending); end
    // busy falls after N+12, IDLE reached at N+13
    cnt = 0;
    while (bus.sending === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    checks++; if (cnt !== 10)             begin failures++; $display("FAIL single_drain_cycles got=%0d exp=10", cnt); end
    checks++; if (bus.empty !== 1'b1)     begin failures++; $display("FAIL single_empty_idle got=%b exp=1", bus.empty); end
    checks++; if (frame_log.size() !== base + 1) begin failures++; $display("FAIL single_frame_count got=%0d exp=%0d", frame_log.size(), base + 1); end
    tick();
  endtask

  task automatic test_burst();
    int base;
    bit ok;
    logic [7:0] got;
    do_reset();
    base = frame_log.size();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h61 + i));
    // Pops at the 2nd and 15th write edges (13-cycle frame cadence): 16 - 2 = 14.
    checks++; if (bus.level !== 5'd14)    begin failures++; $display("FAIL burst_level got=%0d exp=14", bus.level); end
    checks++; if (bus.overflow !== 1'b0)  begin failures++; $display("FAIL burst_overflow got=%b exp=0", bus.overflow); end
    wait_idle(base + 16, 400, ok);
    checks++; if (ok !== 1'b1)            begin failures++; $display("FAIL burst_drain_timeout got=busy exp=idle"); end
    checks++; if (frame_log.size() !== base + 16) begin failures++; $display("FAIL burst_frame_count got=%0d exp=%0d", frame_log.size(), base + 16); end
    for (int i = 0; i < 16; i++) begin
      got = 'x;
      if (base + i < frame_log.size()) got = frame_log[base + i];
      checks++; if (got !== 8'(8'h61 + i)) begin failures++; $display("FAIL burst_frame%0d got=%02h exp=%02h", i, got, 8'(8'h61 + i)); end
    end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    logic [7:0] got;
    hold_busy = 1'b1;
    do_reset();
    base = frame_log.size();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h41 + i));
    checks++; if (bus.full !== 1'b1)      begin failures++; $display("FAIL ovf_full_at16 got=%b exp=1", bus.full); end
    checks++; if (bus.overflow !== 1'b0)  begin failures++; $display("FAIL ovf_none_at16 got=%b exp=0", bus.overflow); end
    write_byte(8'h51);
    checks++; if (bus.level !== 5'd16)    begin failures++; $display("FAIL ovf_level got=%0d exp=16", bus.level); end
    checks++; if (bus.overflow !== 1'b1)  begin failures++; $display("FAIL ovf_sticky_set got=%b exp=1", bus.overflow); end
    checks++; if (bus.sending !== 1'b0)   begin failures++; $display("FAIL ovf_no_pop_busy got=%b exp=0", bus.sending); end
    // Write on the pop edge while full: dropped even though a slot frees up.
    hold_busy = 1'b0;
    write_byte(8'h7A);
    checks++; if (bus.level !== 5'd15)    begin failures++; $display("FAIL simul_level got=%0d exp=15", bus.level); end
    checks++; if (bus.tx_start !== 1'b1)  begin failures++; $display("FAIL simul_tx_start got=%b exp=1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h41)  begin failures++; $display("FAIL simul_tx_data got=%02h exp=41", bus.tx_data); end
    checks++; if (bus.full !== 1'b0)      begin failures++; $display("FAIL simul_full got=%b exp=0", bus.full); end
    wait_idle(base + 16, 400, ok);
    checks++; if (ok !== 1'b1)            begin failures++; $display("FAIL ovf_drain_timeout got=busy exp=idle"); end
    checks++; if (frame_log.size() !== base + 16) begin failures++; $display("FAIL ovf_frame_count got=%0d exp=%0d", frame_log.size(), base + 16); end
    for (int i = 0; i < 16; i++) begin
      got = 'x;
      if (base + i < frame_log.size()) got = frame_log[base + i];
      checks++; if (got !== 8'(8'h41 + i)) begin failures++; $display("FAIL ovf_frame%0d got=%02h exp=%02h", i, got, 8'(8'h41 + i)); end
    end
    checks++; if (bus.overflow !== 1'b1)  begin failures++; $display("FAIL ovf_sticky_after_drain got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_prebusy();
    int base;
    bit ok;
    bit seen;
    logic [7:0] got;
    hold_busy = 1'b1;
    do_reset();
    base = frame_log.size();
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.tx_start !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0)          begin failures++; $display("FAIL prebusy_no_start got=%b exp=0", seen); end
    checks++; if (bus.level !== 5'd3)     begin failures++; $display("FAIL prebusy_level got=%0d exp=3", bus.level); end
    hold_busy = 1'b0;
    wait_idle(base + 3, 100, ok);
    checks++; if (ok !== 1'b1)            begin failures++; $display("FAIL prebusy_drain_timeout got=busy exp=idle"); end
    for (int i = 0; i < 3; i++) begin
      got = 'x;
      if (base + i < frame_log.size()) got = frame_log[base + i];
      checks++; if (got !== 8'(8'h31 + i)) begin failures++; $display("FAIL prebusy_frame%0d got=%02h exp=%02h", i, got, 8'(8'h31 + i)); end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    bit ok;
    bit seen;
    logic [7:0] got;
    hold_busy = 1'b1;
    do_reset();
    base = frame_log.size();
    for (int i = 0; i < 6; i++) write_byte(8'(8'h21 + i));
    hold_busy = 1'b0;
    tick();                                 // pop edge: START with 5 queued
    checks++; if (bus.tx_start !== 1'b1)  begin failures++; $display("FAIL midrst_in_start got=%b exp=1", bus.tx_start); end
    checks++; if (bus.level !== 5'd5)     begin failures++; $display("FAIL midrst_level_before got=%0d exp=5", bus.level); end
    rst_n = 1'b0;
    tick();                                 // edge R; stub accepts the frame here
    rst_n = 1'b1;
    checks++; if (bus.tx_start !== 1'b0)  begin failures++; $display("FAIL midrst_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.level !== 5'd0)     begin failures++; $display("FAIL midrst_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1)     begin failures++; $display("FAIL midrst_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.sending !== 1'b0)   begin failures++; $display("FAIL midrst_sending got=%b exp=0", bus.sending); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.tx_start !== 1'b0) seen = 1'b1;
    end
    // New byte while the pre-reset frame is still busy: must wait for busy to fall.
    write_byte(8'h5A);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.tx_start !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0)          begin failures++; $display("FAIL midrst_no_start_while_busy got=%b exp=0", seen); end
    wait_idle(base + 2, 100, ok);
    checks++; if (ok !== 1'b1)            begin failures++; $display("FAIL midrst_drain_timeout got=busy exp=idle"); end
    checks++; if (frame_log.size() !== base + 2) begin failures++; $display("FAIL midrst_frame_count got=%0d exp=%0d", frame_log.size(), base + 2); end
    got = 'x;
    if (base + 1 < frame_log.size()) got = frame_log[base + 1];
    checks++; if (got !== 8'h5A)          begin failures++; $display("FAIL midrst_next_frame got=%02h exp=5a", got); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_prebusy();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
